// File: rtl/reset_sequencer.sv
// Power-on / request-driven reset sequencer releasing NUM_DOMAINS active-low resets in order.
// Optional watchdog request source compiled in with `define RSTSEQ_WATCHDOG_EN.
module reset_sequencer #(
  parameter int NUM_DOMAINS = 3,
  parameter int CNT_WIDTH   = 12,
  parameter int HOLD_CYCLES = 4095,
  parameter int STAGE_GAP   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int WDT_CYCLES  = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ext_rst_req,
  input  logic                   sw_rst_req,
  input  logic                   wdt_kick,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   pad_oeb_hold,
  output logic                   busy,
  output logic [1:0]             reset_cause,
  output logic [7:0]             reset_count
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_STAGE = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_next;
  logic [IDX_W-1:0]       r_idx, w_idx_next;
  logic [NUM_DOMAINS-1:0] r_rstn, w_rstn_next;
  logic                   r_pad, w_pad_next;
  logic                   r_busy, w_busy_next;
  logic [1:0]             r_cause, w_cause_next;
  logic [7:0]             r_count, w_count_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ext_d;

  logic w_ext_s;
  logic w_wdt_req;
  logic w_req;
  logic w_count_evt;

  assign w_ext_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_ext_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], ext_rst_req};
      r_ext_d <= w_ext_s;
    end
  end

`ifdef RSTSEQ_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] r_wdt;

  // Counter only advances while RUN persists; any request or kick restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdt <= '0;
    end else if (r_state != S_RUN || w_req || wdt_kick) begin
      r_wdt <= '0;
    end else begin
      r_wdt <= r_wdt + WDT_W'(1);
    end
  end

  assign w_wdt_req = (r_state == S_RUN) && !wdt_kick &&
                     (r_wdt == WDT_W'(WDT_CYCLES - 1));
`else
  logic w_unused;

  assign w_unused  = wdt_kick | (WDT_CYCLES < 0);
  assign w_wdt_req = 1'b0;
`endif

  assign w_req = w_ext_s | sw_rst_req | w_wdt_req;
  // A held external level counts only on its rising edge.
  assign w_count_evt = (w_ext_s & ~r_ext_d) | sw_rst_req | w_wdt_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rstn  <= '0;
      r_pad   <= 1'b1;
      r_busy  <= 1'b1;
      r_cause <= 2'b00;
      r_count <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_rstn  <= w_rstn_next;
      r_pad   <= w_pad_next;
      r_busy  <= w_busy_next;
      r_cause <= w_cause_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_rstn_next  = r_rstn;
    w_pad_next   = r_pad;
    w_cause_next = r_cause;
    w_count_next = r_count;

    if (w_req) begin
      w_state_next = S_HOLD;
      w_cnt_next   = '0;
      w_idx_next   = '0;
      w_rstn_next  = '0;
      w_pad_next   = 1'b1;
      if (w_ext_s) begin
        w_cause_next = CAUSE_EXT;
      end else if (sw_rst_req) begin
        w_cause_next = CAUSE_SW;
      end else begin
        w_cause_next = CAUSE_WDT;
      end
      if (w_count_evt && (r_count != 8'hFF)) begin
        w_count_next = r_count + 8'd1;
      end
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == CNT_WIDTH'(HOLD_CYCLES - 1)) begin
            w_rstn_next[0] = 1'b1;
            w_cnt_next     = '0;
            if (NUM_DOMAINS == 1) begin
              w_state_next = S_RUN;
              w_pad_next   = 1'b0;
            end else begin
              w_state_next = S_STAGE;
              w_idx_next   = IDX_W'(1);
            end
          end else begin
            w_cnt_next = r_cnt + CNT_WIDTH'(1);
          end
        end
        S_STAGE: begin
          if (r_cnt == CNT_WIDTH'(STAGE_GAP - 1)) begin
            w_rstn_next[r_idx] = 1'b1;
            w_cnt_next         = '0;
            w_idx_next         = r_idx + IDX_W'(1);
            if (r_idx == IDX_W'(NUM_DOMAINS - 1)) begin
              w_state_next = S_RUN;
              w_pad_next   = 1'b0;
            end
          end else begin
            w_cnt_next = r_cnt + CNT_WIDTH'(1);
          end
        end
        S_RUN: begin
        end
        default: begin
          w_state_next = S_HOLD;
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_rstn_next  = '0;
          w_pad_next   = 1'b1;
        end
      endcase
    end

    w_busy_next = (w_state_next != S_RUN);
  end

  assign rst_n_out    = r_rstn;
  assign pad_oeb_hold = r_pad;
  assign busy         = r_busy;
  assign reset_cause  = r_cause;
  assign reset_count  = r_count;

endmodule
